// File: rtl/boot_run_ctrl.sv
// ============================================================================
// Module      : boot_run_ctrl
// Description : Boot/run sequencer for the single-cycle RISC-V core. It loads
//               the program image, holds the core in reset, then runs it until
//               ECALL/EBREAK or the cycle limit is reached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_run_ctrl #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 10000,
    parameter int LOAD_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    input  logic [XLEN-1:0]   load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              cpu_rst,
    input  logic              retire_valid,
    input  logic [31:0]       retire_instr,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              halt_ecall
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HOLD    = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam int               HOLD_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
    localparam logic [31:0]       c_ECALL      = 32'h0000_0073;
    localparam logic [31:0]       c_EBREAK     = 32'h0010_0073;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [ADDR_W-1:0]   r_ptr;

    logic                r_load_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [XLEN-1:0]     r_imem_wdata;
    logic                r_cpu_rst;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [CNT_W-1:0]    r_instr_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic                r_halt_ecall;

    logic                w_start;
    logic                w_accept;
    logic                w_is_ecall;
    logic                w_halt;
    logic                w_last_cycle;

    always_comb begin
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_is_ecall   = (retire_instr == c_ECALL);
        w_halt       = 1'b0;
        w_last_cycle = 1'b0;
        w_state_nxt  = r_state;

        case (r_state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                w_start = start;
                if (start) begin
                    w_state_nxt = (LOAD_EN != 0) ? S_LOAD : S_HOLD;
                end
            end
            S_LOAD: begin
                w_accept = load_valid && r_load_ready;
                if (w_accept && load_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_halt       = retire_valid && (w_is_ecall || (retire_instr == c_EBREAK));
                w_last_cycle = (r_cycle_cnt == c_LAST_CYCLE);
                // A halt retiring on the final allowed cycle wins over timeout.
                if (w_halt) begin
                    w_state_nxt = S_DONE;
                end else if (w_last_cycle) begin
                    w_state_nxt = S_TIMEOUT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hold_cnt   <= '0;
            r_ptr        <= '0;
            r_load_ready <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst    <= 1'b1;
            r_cycle_cnt  <= '0;
            r_instr_cnt  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_halt_ecall <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // Status outputs are decoded from the next state so they line up
            // with the state they describe.
            r_load_ready <= (w_state_nxt == S_LOAD);
            r_cpu_rst    <= (w_state_nxt != S_RUN);
            r_busy       <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_HOLD) ||
                            (w_state_nxt == S_RUN);
            r_imem_we    <= w_accept;

            if (w_accept) begin
                r_imem_addr  <= r_ptr;
                r_imem_wdata <= load_data;
                r_ptr        <= r_ptr + ADDR_W'(1);
            end

            r_hold_cnt <= (r_state == S_HOLD) ? (r_hold_cnt + HOLD_W'(1)) : '0;

            if (w_start) begin
                r_ptr        <= '0;
                r_cycle_cnt  <= '0;
                r_instr_cnt  <= '0;
                r_done       <= 1'b0;
                r_timeout    <= 1'b0;
                r_halt_ecall <= 1'b0;
            end

            if (r_state == S_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                if (retire_valid) begin
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                end
            end

            if (w_halt) begin
                r_done       <= 1'b1;
                r_halt_ecall <= w_is_ecall;
            end else if (w_last_cycle) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign load_ready  = r_load_ready;
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign cpu_rst     = r_cpu_rst;
    assign cycle_count = r_cycle_cnt;
    assign instr_count = r_instr_cnt;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign halt_ecall  = r_halt_ecall;

endmodule

`default_nettype wire

// File: tb/tb_boot_run_ctrl.sv
// ============================================================================
// Module      : tb_boot_run_ctrl
// Description : Scoreboard bench for boot_run_ctrl with directed load/run vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_run_ctrl;

    localparam int ADDR_W  = 2;
    localparam int MAX_CYC = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              load_valid = 1'b0;
    logic [31:0]       load_data = '0;
    logic              load_last = 1'b0;
    logic              retire_valid = 1'b0;
    logic [31:0]       retire_instr = '0;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic [31:0]       cycle_count;
    logic [31:0]       instr_count;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              halt_ecall;

    boot_run_ctrl #(
        .XLEN(32), .ADDR_W(ADDR_W), .CNT_W(32),
        .RST_CYCLES(2), .MAX_CYCLES(MAX_CYC), .LOAD_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
        .retire_valid(retire_valid), .retire_instr(retire_instr),
        .cycle_count(cycle_count), .instr_count(instr_count),
        .busy(busy), .done(done), .timeout(timeout), .halt_ecall(halt_ecall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    // f = {done, timeout, halt_ecall}
    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] cyc;
        logic [31:0] ins;
    } res_t;

    wr_t               wq[$];
    res_t              rq[$];
    logic [ADDR_W-1:0] m_ptr = '0;
    logic              prev_end = 1'b0;
    int                n_vec = 0;
    int                n_err = 0;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Write monitor: every imem write must match the oldest expected beat.
    always @(negedge clk) begin
        wr_t w;
        if (imem_we) begin
            if (wq.size() == 0) begin
                fail_now("unexpected_imem_write");
            end else begin
                w = wq.pop_front();
                check("imem_addr", 64'(imem_addr), 64'(w.a));
                check("imem_wdata", 64'(imem_wdata), 64'(w.d));
            end
        end
    end

    // Session-end monitor: compares status and counters on done/timeout rise.
    always @(negedge clk) begin
        res_t r;
        if ((done || timeout) && !prev_end) begin
            if (rq.size() == 0) begin
                fail_now("unexpected_session_end");
            end else begin
                r = rq.pop_front();
                check("end_flags", 64'({done, timeout, halt_ecall}), 64'(r.f));
                check("cycle_count", 64'(cycle_count), 64'(r.cyc));
                check("instr_count", 64'(instr_count), 64'(r.ins));
                check("end_cpu_rst_busy", 64'({cpu_rst, busy}), 64'(2'b10));
            end
        end
        prev_end = done || timeout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        m_ptr = '0;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        logic acc;
        acc        = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        for (int i = 0; i < 20; i++) begin
            acc = load_ready;
            tick();
            if (acc) break;
        end
        if (!acc) fail_now("load_accept_timeout");
        wq.push_back({m_ptr, d});
        m_ptr      = m_ptr + 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (cpu_rst && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || timeout) && n < 100) begin
            n++;
            tick();
        end
        if (!(done || timeout)) fail_now("run_end_timeout");
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_flags"}, 64'({cpu_rst, load_ready, imem_we, busy, done, timeout, halt_ecall}),
              64'(7'b1000000));
        check({nm, "_imem"}, 64'({imem_addr, imem_wdata}), 64'd0);
        check({nm, "_counters"}, {cycle_count, instr_count}, 64'd0);
    endtask

    initial begin
        int hold_n;

        rst = 1'b1;
        tick();
        tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        // Three-word image, EBREAK halt after two retirements.
        do_start();
        check("load_ready_first", 64'({load_ready, busy}), 64'(2'b11));
        send(32'h0050_0093, 1'b0);
        send(EBREAK, 1'b0);
        send(NOP, 1'b1);
        check("load_ready_after_last", 64'(load_ready), 64'd0);
        wait_run(hold_n);
        check("hold_cycles_t1", 64'(hold_n), 64'd2);
        rq.push_back({3'b100, 32'd2, 32'd2});
        retire_valid = 1'b1;
        retire_instr = 32'h0050_0093;
        tick();
        retire_instr = EBREAK;
        tick();
        retire_valid = 1'b0;
        wait_end();

        // Restart from DONE clears status; gapped load then timeout run.
        do_start();
        check("restart_cleared", {cycle_count, instr_count}, 64'd0);
        check("restart_flags", 64'({done, timeout, halt_ecall, load_ready}), 64'(4'b0001));
        send(32'hAAAA_0001, 1'b0);
        tick();
        send(32'hBBBB_0002, 1'b1);
        wait_run(hold_n);
        check("hold_cycles_t2", 64'(hold_n), 64'd2);
        rq.push_back({3'b010, 32'd16, 32'd16});
        retire_valid = 1'b1;
        retire_instr = NOP;
        wait_end();
        retire_valid = 1'b0;

        // ECALL exactly on the last allowed cycle beats timeout.
        do_start();
        send(ECALL, 1'b1);
        wait_run(hold_n);
        rq.push_back({3'b101, 32'd16, 32'd16});
        retire_valid = 1'b1;
        retire_instr = NOP;
        repeat (15) tick();
        retire_instr = ECALL;
        tick();
        retire_valid = 1'b0;
        wait_end();

        // Five words into a four-word memory: the fifth overwrites word 0.
        do_start();
        for (int i = 0; i < 5; i++) begin
            send(32'hC0DE_0000 + 32'(i), (i == 4));
        end
        wait_run(hold_n);
        check("hold_cycles_wrap", 64'(hold_n), 64'd2);
        rq.push_back({3'b101, 32'd1, 32'd1});
        retire_valid = 1'b1;
        retire_instr = ECALL;
        tick();
        retire_valid = 1'b0;
        wait_end();

        // Reset in the same cycle as an accepted beat drops the write.
        do_start();
        send(32'h0000_0011, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'h0000_0022;
        rst        = 1'b1;
        tick();
        check_reset("rst_mid_load");
        rst        = 1'b0;
        load_valid = 1'b0;
        tick();

        // start during RUN is ignored; reset then aborts the run.
        do_start();
        send(NOP, 1'b1);
        wait_run(hold_n);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run_ignored", 64'({cpu_rst, load_ready, busy}), 64'(3'b001));
        check("run_cycle_count", 64'(cycle_count), 64'd3);
        rst = 1'b1;
        tick();
        check_reset("rst_mid_run");
        rst = 1'b0;
        repeat (3) tick();

        check("write_queue_drained", 64'(wq.size()), 64'd0);
        check("result_queue_drained", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
